// File: rtl/hyperbus_rwds_calib.sv
// HyperBus RWDS sampler calibration.
// Sweeps all 32 sampler edge positions and runs NumTrials calibration reads at
// each one. A position passes only if every trial returned the expected RWDS
// value. The centre of the longest contiguous passing run is then selected.
// If no position passes, fail_o is raised and the configuration that was
// active before the sweep is restored.
module hyperbus_rwds_calib #(
   parameter int NumTrials    = 4,   // trials per edge position, 1..15
   parameter int SettleCycles = 8    // idle cycles after a cfg change, 1..255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        expected_rwds_i,
   output logic        trial_req_o,
   input  logic        trial_ack_i,
   input  logic        trial_done_i,
   input  logic        rwds_sample_i,
   output logic [3:0]  cfg_edge_idx_o,
   output logic        cfg_edge_pol_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        fail_o,
   output logic [31:0] pass_map_o
);

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      REQ,
      WAIT,
      EVAL,
      SEARCH,
      DONE
   } state_t;

   state_t      r_state;
   logic [4:0]  r_pos;
   logic [7:0]  r_settle_cnt;
   logic [3:0]  r_trial_cnt;
   logic        r_mismatch;
   logic        r_expected;
   logic [3:0]  r_cfg_idx;
   logic        r_cfg_pol;
   logic [3:0]  r_saved_idx;
   logic        r_saved_pol;
   logic        r_trial_req;
   logic        r_busy;
   logic        r_done;
   logic        r_fail;
   logic [31:0] r_pass_map;

   // Run tracking for the search phase
   logic [4:0]  r_scan;
   logic [4:0]  r_cur_start;
   logic [5:0]  r_cur_len;
   logic [4:0]  r_best_start;
   logic [5:0]  r_best_len;

   logic        w_bit;
   logic [4:0]  w_cur_start;
   logic [5:0]  w_cur_len;
   logic [4:0]  w_best_start;
   logic [5:0]  w_best_len;
   logic [4:0]  w_half;
   logic [4:0]  w_result;

   localparam logic [3:0] LastTrial  = 4'(NumTrials - 1);
   localparam logic [7:0] LastSettle = 8'(SettleCycles - 1);

   // Next run-tracking values after absorbing the bit under the scan pointer.
   // A later run replaces the best one only when strictly longer, so the
   // lowest-start run wins a tie.
   always_comb begin
      w_bit        = r_pass_map[r_scan];
      w_cur_len    = 6'd0;
      w_cur_start  = r_cur_start;
      w_best_len   = r_best_len;
      w_best_start = r_best_start;
      if (w_bit) begin
         w_cur_len = r_cur_len + 6'd1;
         if (r_cur_len == 6'd0) begin
            w_cur_start = r_scan;
         end
         if (w_cur_len > r_best_len) begin
            w_best_len   = w_cur_len;
            w_best_start = w_cur_start;
         end
      end
   end

   // Centre of the best run, biased toward the start for even lengths
   assign w_half   = 5'((w_best_len - 6'd1) >> 1);
   assign w_result = w_best_start + w_half;

   // Calibration sequencer: every output is registered here
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_pos        <= 5'd0;
         r_settle_cnt <= 8'd0;
         r_trial_cnt  <= 4'd0;
         r_mismatch   <= 1'b0;
         r_expected   <= 1'b0;
         r_cfg_idx    <= 4'd1;
         r_cfg_pol    <= 1'b1;
         r_saved_idx  <= 4'd1;
         r_saved_pol  <= 1'b1;
         r_trial_req  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_fail       <= 1'b0;
         r_pass_map   <= 32'd0;
         r_scan       <= 5'd0;
         r_cur_start  <= 5'd0;
         r_cur_len    <= 6'd0;
         r_best_start <= 5'd0;
         r_best_len   <= 6'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_saved_idx  <= r_cfg_idx;
                  r_saved_pol  <= r_cfg_pol;
                  r_pass_map   <= 32'd0;
                  r_fail       <= 1'b0;
                  r_pos        <= 5'd0;
                  r_expected   <= expected_rwds_i;
                  r_cfg_idx    <= 4'd0;
                  r_cfg_pol    <= 1'b0;
                  r_settle_cnt <= 8'd0;
                  r_trial_cnt  <= 4'd0;
                  r_mismatch   <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= APPLY;
               end
            end

            APPLY: begin
               if (r_settle_cnt == LastSettle) begin
                  r_settle_cnt <= 8'd0;
                  r_trial_req  <= 1'b1;
                  r_state      <= REQ;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 8'd1;
               end
            end

            REQ: begin
               if (trial_ack_i) begin
                  r_trial_req <= 1'b0;
                  r_state     <= WAIT;
               end
            end

            WAIT: begin
               if (trial_done_i) begin
                  if (rwds_sample_i != r_expected) begin
                     r_mismatch <= 1'b1;
                  end
                  if (r_trial_cnt == LastTrial) begin
                     r_trial_cnt <= 4'd0;
                     r_state     <= EVAL;
                  end else begin
                     r_trial_cnt <= r_trial_cnt + 4'd1;
                     r_trial_req <= 1'b1;
                     r_state     <= REQ;
                  end
               end
            end

            EVAL: begin
               r_pass_map[r_pos] <= ~r_mismatch;
               r_mismatch        <= 1'b0;
               if (r_pos == 5'd31) begin
                  r_scan       <= 5'd0;
                  r_cur_start  <= 5'd0;
                  r_cur_len    <= 6'd0;
                  r_best_start <= 5'd0;
                  r_best_len   <= 6'd0;
                  r_state      <= SEARCH;
               end else begin
                  r_pos     <= r_pos + 5'd1;
                  r_cfg_idx <= (r_pos + 5'd1) >> 1;
                  r_cfg_pol <= ~r_pos[0];
                  r_state   <= APPLY;
               end
            end

            SEARCH: begin
               r_cur_len    <= w_cur_len;
               r_cur_start  <= w_cur_start;
               r_best_len   <= w_best_len;
               r_best_start <= w_best_start;
               if (r_scan == 5'd31) begin
                  // Final bit absorbed: publish the result together with done
                  r_done <= 1'b1;
                  if (w_best_len != 6'd0) begin
                     r_cfg_idx <= w_result[4:1];
                     r_cfg_pol <= w_result[0];
                  end else begin
                     r_fail    <= 1'b1;
                     r_cfg_idx <= r_saved_idx;
                     r_cfg_pol <= r_saved_pol;
                  end
                  r_state <= DONE;
               end else begin
                  r_scan <= r_scan + 5'd1;
               end
            end

            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign trial_req_o    = r_trial_req;
   assign cfg_edge_idx_o = r_cfg_idx;
   assign cfg_edge_pol_o = r_cfg_pol;
   assign busy_o         = r_busy;
   assign done_o         = r_done;
   assign fail_o         = r_fail;
   assign pass_map_o     = r_pass_map;

endmodule

// File: tb/tb_hyperbus_rwds_calib.sv
// Directed bench for hyperbus_rwds_calib with a small PHY/sampler responder.
// Each sweep pushes its expected outcome to a scoreboard queue; the entry is
// popped and compared when done_o fires.
module tb_hyperbus_rwds_calib;

   localparam int NumTrials    = 4;
   localparam int SettleCycles = 8;

   logic        clk_i;
   logic        rst_ni;
   logic        start_i;
   logic        expected_rwds_i;
   logic        trial_req_o;
   logic        trial_ack_i;
   logic        trial_done_i;
   logic        rwds_sample_i;
   logic [3:0]  cfg_edge_idx_o;
   logic        cfg_edge_pol_o;
   logic        busy_o;
   logic        done_o;
   logic        fail_o;
   logic [31:0] pass_map_o;

   hyperbus_rwds_calib #(
      .NumTrials   (NumTrials),
      .SettleCycles(SettleCycles)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .start_i        (start_i),
      .expected_rwds_i(expected_rwds_i),
      .trial_req_o    (trial_req_o),
      .trial_ack_i    (trial_ack_i),
      .trial_done_i   (trial_done_i),
      .rwds_sample_i  (rwds_sample_i),
      .cfg_edge_idx_o (cfg_edge_idx_o),
      .cfg_edge_pol_o (cfg_edge_pol_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .fail_o         (fail_o),
      .pass_map_o     (pass_map_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] map;
      logic [3:0]  idx;
      logic        pol;
      logic        fail;
   } exp_t;

   exp_t sb_q[$];

   // Responder configuration, written by the main sequence between sweeps
   logic [31:0] pat         = 32'd0;
   logic        tb_exp      = 1'b0;
   int          partial_pos = -1;
   int          phy_latency = 2;
   int          trial_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   // PHY model: acks a request for one cycle, then after phy_latency cycles
   // pulses trial_done_i with a sample that matches when the position is in
   // the pass pattern (trial 1 at partial_pos is forced to mismatch).
   initial begin
      int         wait_cnt;
      bit         pending;
      bit         ok;
      logic [4:0] pos;
      trial_ack_i   = 1'b0;
      trial_done_i  = 1'b0;
      rwds_sample_i = 1'b0;
      wait_cnt      = 0;
      pending       = 1'b0;
      pos           = 5'd0;
      forever begin
         @(negedge clk_i);
         trial_done_i = 1'b0;
         if (trial_ack_i) begin
            trial_ack_i = 1'b0;
            pending     = 1'b1;
            wait_cnt    = phy_latency;
         end else if (pending) begin
            if (wait_cnt > 0) begin
               wait_cnt--;
            end else begin
               pending = 1'b0;
               ok = pat[pos] && !((int'(pos) == partial_pos) && ((trial_total % NumTrials) == 1));
               rwds_sample_i = ok ? tb_exp : ~tb_exp;
               trial_done_i  = 1'b1;
               trial_total++;
            end
         end else if (trial_req_o) begin
            trial_ack_i = 1'b1;
            pos         = {cfg_edge_idx_o, cfg_edge_pol_o};
         end
      end
   end

   task automatic run_sweep(input string name, input logic [31:0] p, input logic e,
                            input int part_pos, input logic [31:0] m, input logic [3:0] ix,
                            input logic pl, input logic fl, input bit poke_start);
      exp_t x;
      int   cyc;
      pat         = p;
      tb_exp      = e;
      partial_pos = part_pos;
      trial_total = 0;
      x.map  = m;
      x.idx  = ix;
      x.pol  = pl;
      x.fail = fl;
      sb_q.push_back(x);
      @(negedge clk_i);
      expected_rwds_i = e;
      start_i         = 1'b1;
      @(negedge clk_i);
      start_i         = 1'b0;
      expected_rwds_i = ~e;
      check({name, " busy_after_start"}, 32'(busy_o), 32'd1);
      if (poke_start) begin
         repeat (100) @(negedge clk_i);
         start_i = 1'b1;
         @(negedge clk_i);
         start_i = 1'b0;
      end
      cyc = 0;
      while (!done_o && cyc < 20000) begin
         @(negedge clk_i);
         cyc++;
      end
      check({name, " done_seen"}, 32'(done_o), 32'd1);
      x = sb_q.pop_front();
      if (done_o) begin
         check({name, " pass_map"}, pass_map_o, x.map);
         check({name, " cfg_idx"}, 32'(cfg_edge_idx_o), 32'(x.idx));
         check({name, " cfg_pol"}, 32'(cfg_edge_pol_o), 32'(x.pol));
         check({name, " fail"}, 32'(fail_o), 32'(x.fail));
         check({name, " trials"}, 32'(trial_total), 32'(32 * NumTrials));
         @(negedge clk_i);
         check({name, " done_pulse_end"}, 32'(done_o), 32'd0);
         check({name, " busy_end"}, 32'(busy_o), 32'd0);
         check({name, " cfg_hold"}, 32'({cfg_edge_idx_o, cfg_edge_pol_o}), 32'({x.idx, x.pol}));
      end
      $display("sweep %s: pass_map=0x%08h idx=%0d pol=%0d fail=%0d", name, pass_map_o,
               cfg_edge_idx_o, cfg_edge_pol_o, fail_o);
   endtask

   initial begin
      int cyc;
      rst_ni          = 1'b0;
      start_i         = 1'b0;
      expected_rwds_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("reset cfg_idx", 32'(cfg_edge_idx_o), 32'd1);
      check("reset cfg_pol", 32'(cfg_edge_pol_o), 32'd1);
      check("reset busy", 32'(busy_o), 32'd0);
      check("reset pass_map", pass_map_o, 32'd0);
      check("reset done", 32'(done_o), 32'd0);
      check("reset fail", 32'(fail_o), 32'd0);
      check("reset trial_req", 32'(trial_req_o), 32'd0);
      $display("reset: idx=%0d pol=%0d busy=%0d", cfg_edge_idx_o, cfg_edge_pol_o, busy_o);

      run_sweep("run5_9",      32'h0000_03E0, 1'b1, -1, 32'h0000_03E0, 4'd3,  1'b1, 1'b0, 1'b1);
      run_sweep("partial9",    32'h0000_03E0, 1'b0,  9, 32'h0000_01E0, 4'd3,  1'b0, 1'b0, 1'b0);
      run_sweep("two_runs",    32'h03F0_001C, 1'b0, -1, 32'h03F0_001C, 4'd11, 1'b0, 1'b0, 1'b0);
      run_sweep("all_pass",    32'hFFFF_FFFF, 1'b1, -1, 32'hFFFF_FFFF, 4'd7,  1'b1, 1'b0, 1'b0);
      run_sweep("tie_low",     32'h0000_3C0F, 1'b1, -1, 32'h0000_3C0F, 4'd0,  1'b1, 1'b0, 1'b0);
      run_sweep("top_no_wrap", 32'hF000_0001, 1'b0, -1, 32'hF000_0001, 4'd14, 1'b1, 1'b0, 1'b0);
      run_sweep("single4",     32'h0000_0010, 1'b1, -1, 32'h0000_0010, 4'd2,  1'b0, 1'b0, 1'b0);
      run_sweep("none_pass",   32'h0000_0000, 1'b1, -1, 32'h0000_0000, 4'd2,  1'b0, 1'b1, 1'b0);

      // Reset while waiting for a trial to finish; the late done must be ignored
      pat         = 32'hFFFF_FFFF;
      tb_exp      = 1'b1;
      partial_pos = -1;
      phy_latency = 6;
      @(negedge clk_i);
      expected_rwds_i = 1'b1;
      start_i         = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      check("restart clears fail", 32'(fail_o), 32'd0);
      cyc = 0;
      do begin
         @(negedge clk_i);
         #2;
         cyc++;
      end while (!trial_ack_i && cyc < 200);
      check("ack_seen", 32'(trial_ack_i), 32'd1);
      @(posedge clk_i);
      #2;
      check("in_wait busy", 32'(busy_o), 32'd1);
      check("in_wait cfg", 32'({cfg_edge_idx_o, cfg_edge_pol_o}), 32'd0);
      rst_ni = 1'b0;
      #1;
      check("midreset cfg_idx", 32'(cfg_edge_idx_o), 32'd1);
      check("midreset cfg_pol", 32'(cfg_edge_pol_o), 32'd1);
      check("midreset busy", 32'(busy_o), 32'd0);
      check("midreset trial_req", 32'(trial_req_o), 32'd0);
      check("midreset done", 32'(done_o), 32'd0);
      check("midreset fail", 32'(fail_o), 32'd0);
      check("midreset pass_map", pass_map_o, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (12) @(negedge clk_i);
      check("late_done busy", 32'(busy_o), 32'd0);
      check("late_done trial_req", 32'(trial_req_o), 32'd0);
      check("late_done pass_map", pass_map_o, 32'd0);
      check("late_done cfg", 32'({cfg_edge_idx_o, cfg_edge_pol_o}), 32'h3);
      $display("midsweep reset: busy=%0d idx=%0d pol=%0d", busy_o, cfg_edge_idx_o, cfg_edge_pol_o);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net in case a wait is somehow never satisfied
   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
